// File: rtl/count_stream_buffer.sv
// count_stream_buffer: wrap-tagging FIFO behind a valid/ready stream for a free-running counter.
// Optional COUNT_STREAM_GAP_CHECK_EN flags non-consecutive accepted counts on gap_err.
module count_stream_buffer #(
  parameter int N = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N-1:0]               cnt_in,
  input  logic                       cnt_vld,
  output logic [N-1:0]               out_data,
  output logic                       out_wrap,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic                       gap_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [N:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [AW:0] rem, lvl_n;
  logic [N-1:0] last;
  logic first, push, pop, drop, wrap_n;
  logic [N:0] head_n;
  always_comb begin
    push = cnt_vld && level != FULL;
    drop = cnt_vld && level == FULL;
    pop = out_vld && out_rdy;
    wrap_n = !first && cnt_in < last;
    rd_n = rd + AW'(pop);
    rem = level - (AW+1)'(pop);
    lvl_n = rem + (AW+1)'(push);
    // With nothing left after the pop, the incoming word becomes the new head
    head_n = rem == '0 ? {wrap_n, cnt_in} : mem[rd_n];
  end
  always_ff @(posedge clk)
    if (push) mem[wr] <= {wrap_n, cnt_in};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
      out_vld <= 1'b0;
      out_data <= '0;
      out_wrap <= 1'b0;
      ovf <= 1'b0;
      first <= 1'b1;
      last <= '0;
    end else begin
      rd <= rd_n;
      wr <= wr + AW'(push);
      level <= lvl_n;
      out_vld <= lvl_n != '0;
      if (lvl_n != '0) {out_wrap, out_data} <= head_n;
      ovf <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf;
      if (push) begin
        first <= 1'b0;
        last <= cnt_in;
      end
    end
`ifdef COUNT_STREAM_GAP_CHECK_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) gap_err <= 1'b0;
    else if (push && !first && cnt_in != last + N'(1)) gap_err <= 1'b1;
`else
  assign gap_err = 1'b0;
`endif
endmodule

// File: tb/tb_count_stream_buffer.sv
// tb_count_stream_buffer: directed checks of count_stream_buffer at N=10 and N=4.
module tb_count_stream_buffer;
  logic clk = 1'b0, resetn = 1'b0;
  logic [9:0] cnt_a = '0, data_a;
  logic vld_a = 1'b0, rdy_a = 1'b0, clr_a = 1'b0, wrap_a, ovld_a, ovf_a, gap_a;
  logic [2:0] lvl_a, lvl_b;
  logic [3:0] cnt_b = '0, data_b;
  logic vld_b = 1'b0, rdy_b = 1'b0, clr_b = 1'b0, wrap_b, ovld_b, ovf_b, gap_b;
  int compared = 0, mismatched = 0;
  logic gap_exp;
  always #5 clk = ~clk;
  count_stream_buffer #(.N(10), .DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .cnt_in(cnt_a), .cnt_vld(vld_a),
    .out_data(data_a), .out_wrap(wrap_a), .out_vld(ovld_a), .out_rdy(rdy_a),
    .level(lvl_a), .ovf(ovf_a), .ovf_clr(clr_a), .gap_err(gap_a));
  count_stream_buffer #(.N(4), .DEPTH(4)) dut_b (
    .clk(clk), .resetn(resetn), .cnt_in(cnt_b), .cnt_vld(vld_b),
    .out_data(data_b), .out_wrap(wrap_b), .out_vld(ovld_b), .out_rdy(rdy_b),
    .level(lvl_b), .ovf(ovf_b), .ovf_clr(clr_b), .gap_err(gap_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [9:0] v);
    cnt_a = v;
    vld_a = 1'b1;
    tick();
  endtask
  initial begin
`ifdef COUNT_STREAM_GAP_CHECK_EN
    gap_exp = 1'b1;
`else
    gap_exp = 1'b0;
`endif
    #3;
    chk("rst_level", lvl_a, 0);
    chk("rst_vld", ovld_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_gap", gap_a, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    // Test 1: streaming with consumer always ready
    rdy_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_a(10'(i));
      chk("t1_vld", ovld_a, 1);
      chk("t1_data", data_a, i);
      chk("t1_wrap", wrap_a, 0);
      chk("t1_level", lvl_a, 1);
    end
    vld_a = 1'b0;
    tick();
    chk("t1_empty_vld", ovld_a, 0);
    chk("t1_hold_data", data_a, 2);
    chk("t1_ovf", ovf_a, 0);
    // Test 3: N=4 wrap tagging 14,15,0,1
    rdy_b = 1'b1;
    vld_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt_b = 4'(14 + i);
      tick();
      chk("t3_data", data_b, (14 + i) % 16);
      chk("t3_wrap", wrap_b, i == 2);
      chk("t3_gap", gap_b, 0);
    end
    vld_b = 1'b0;
    // Test 2: fill while stalled, overflow drop, drain
    rdy_a = 1'b0;
    for (int i = 5; i < 9; i++) push_a(10'(i));
    chk("t2_full", lvl_a, 4);
    chk("t2_head", data_a, 5);
    chk("t2_ovf_before", ovf_a, 0);
    push_a(10'd9);
    chk("t2_drop_level", lvl_a, 4);
    chk("t2_ovf", ovf_a, 1);
    vld_a = 1'b0;
    rdy_a = 1'b1;
    for (int i = 6; i < 9; i++) begin
      tick();
      chk("t2_drain", data_a, i);
      chk("t2_drain_lvl", lvl_a, 9 - i);
    end
    tick();
    chk("t2_empty", ovld_a, 0);
    chk("t2_ovf_sticky", ovf_a, 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("t2_ovf_clr", ovf_a, 0);
    // Dropped 9 did not update last-accepted, so 7 < 8 wraps
    push_a(10'd7);
    chk("t2_wrap_data", data_a, 7);
    chk("t2_wrap_tag", wrap_a, 1);
    vld_a = 1'b0;
    tick();
    chk("t2_empty2", lvl_a, 0);
    // Test 5: push+pop at full, then at level 2
    rdy_a = 1'b0;
    for (int i = 10; i < 14; i++) push_a(10'(i));
    chk("t5_full", lvl_a, 4);
    chk("t5_wrap10", wrap_a, 0);
    rdy_a = 1'b1;
    push_a(10'd14);
    chk("t5_level3", lvl_a, 3);
    chk("t5_ovf", ovf_a, 1);
    chk("t5_head11", data_a, 11);
    vld_a = 1'b0;
    tick();
    chk("t5_level2", lvl_a, 2);
    push_a(10'd15);
    chk("t5_pp_level", lvl_a, 2);
    chk("t5_head13", data_a, 13);
    vld_a = 1'b0;
    tick();
    chk("t5_head15", data_a, 15);
    chk("t5_level1", lvl_a, 1);
    tick();
    chk("t5_empty", ovld_a, 0);
    // Test 6: async reset with three words buffered
    rdy_a = 1'b0;
    for (int i = 20; i < 23; i++) push_a(10'(i));
    vld_a = 1'b0;
    chk("t6_level3", lvl_a, 3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_vld", ovld_a, 0);
    chk("t6_async_level", lvl_a, 0);
    chk("t6_async_ovf", ovf_a, 0);
    @(negedge clk);
    resetn = 1'b1;
    // Test 4: first word after reset, then a gap
    rdy_a = 1'b1;
    push_a(10'd3);
    chk("t4_data3", data_a, 3);
    chk("t4_wrap_first", wrap_a, 0);
    chk("t4_gap_first", gap_a, 0);
    push_a(10'd5);
    vld_a = 1'b0;
    chk("t4_data5", data_a, 5);
    chk("t4_gap", gap_a, gap_exp);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    chk("t4_gap_sticky", gap_a, gap_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
